// File: rtl/timer_arbiter_pkg.sv
// Shared types and constants for the timer arbiter: FSM state encoding,
// default dimensions and a small index-wrap helper.
package timer_arbiter_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Next requester index after idx, wrapping back to 0 past n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting at ptr and
// wrapping modulo NREQ, returning the first asserted one as one-hot and index.
module rr_pick
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            win_vld
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    int unsigned       pos_s;

    // Rotate the request vector so bit k is requester (ptr+k) mod NREQ.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[NREQ-1:0];
    end

    // Take the lowest rotated request and map it back to its real index.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        pos_s   = 32'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld && rot_s[k]) begin
                win_vld = 1'b1;
                pos_s   = 32'(ptr) + 32'(k);
                if (pos_s >= 32'(NREQ)) begin
                    pos_s = pos_s - 32'(NREQ);
                end else begin
                    pos_s = pos_s;
                end
                win_idx = PW'(pos_s);
            end else begin
                win_vld = win_vld;
            end
        end
        if (win_vld) begin
            win_oh = NREQ'(1'b1) << win_idx;
        end else begin
            win_oh = '0;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Timer arbiter: grants a shared CW-bit up-counter to one requester at a
// time in round-robin order, counts len+1 cycles, then pulses done.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CW-1:0]        cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_r, state_s;
    logic [PW-1:0]   ptr_r, ptr_s;
    logic [PW-1:0]   win_r, win_s;
    logic [CW-1:0]   len_r, len_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [NREQ-1:0] done_r, done_s;
    logic            busy_r, busy_s;
    logic [CW-1:0]   cnt_r, cnt_s;

    logic [NREQ-1:0] pick_oh_s;
    logic [PW-1:0]   pick_idx_s;
    logic            pick_vld_s;
    logic [CW-1:0]   pick_len_s;
    logic [PW-1:0]   ptr_inc_s;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_r),
        .win_oh  (pick_oh_s),
        .win_idx (pick_idx_s),
        .win_vld (pick_vld_s)
    );

    // Select the length slice belonging to the current round-robin winner.
    always_comb begin
        pick_len_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh_s[i]) begin
                pick_len_s = req_len[i*CW +: CW];
            end else begin
                pick_len_s = pick_len_s;
            end
        end
    end

    // Pointer value that makes the requester after the current winner first in line.
    always_comb begin
        ptr_inc_s = PW'(wrap_inc(32'(win_r), 32'(NREQ)));
    end

    // Next-state and next-output logic for the grant sequencer.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        len_s   = len_r;
        gnt_s   = gnt_r;
        done_s  = '0;
        busy_s  = busy_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_s = ST_RUN;
                    win_s   = pick_idx_s;
                    len_s   = pick_len_s;
                    gnt_s   = pick_oh_s;
                    busy_s  = 1'b1;
                    cnt_s   = '0;
                end else begin
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                end
            end
            ST_RUN: begin
                if ((req & gnt_r) == '0) begin
                    // Granted requester withdrew: abandon the run silently.
                    state_s = ST_IDLE;
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                    ptr_s   = ptr_inc_s;
                end else if (cnt_r == len_r) begin
                    state_s = ST_DONE;
                    done_s  = gnt_r;
                    gnt_s   = '0;
                    busy_s  = 1'b1;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CW'(1'b1);
                end
            end
            ST_DONE: begin
                // Requests are ignored here, giving one idle cycle between grants.
                state_s = ST_IDLE;
                ptr_s   = ptr_inc_s;
                gnt_s   = '0;
                busy_s  = 1'b0;
                cnt_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                ptr_s   = '0;
                gnt_s   = '0;
                busy_s  = 1'b0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            len_r   <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            len_r   <= len_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    assign gnt  = gnt_r;
    assign done = done_r;
    assign busy = busy_r;
    assign cnt  = cnt_r;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: a per-cycle vector table plus
// hand-built sequences; expectations flow through a scoreboard queue.
module tb_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*CW-1:0]  req_len;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [CW-1:0]       cnt;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [3:0] cnt;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [3:0] g, input logic [3:0] d,
                                input logic b, input logic [3:0] c);
        obs_t o;
        o.gnt  = g;
        o.done = d;
        o.busy = b;
        o.cnt  = c;
        return o;
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                       input logic [3:0] g, input logic [3:0] d, input logic b,
                       input logic [3:0] c);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.len = ln;
        v.exp = mk(g, d, b, c);
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input string tag, input int id, input logic r,
                        input logic [3:0] rq, input logic [15:0] ln, input obs_t e);
        obs_t got;
        obs_t want;
        rst     = r;
        req     = rq;
        req_len = ln;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = mk(gnt, done, busy, cnt);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got gnt=%b done=%b busy=%b cnt=%0d expected gnt=%b done=%b busy=%b cnt=%0d",
                     tag, id, got.gnt, got.done, got.busy, got.cnt,
                     want.gnt, want.done, want.busy, want.cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b0000;
        req_len = 16'h0000;

        // reset
        add(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        add(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        // single request, len 3
        add(1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd1);
        add(1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd2);
        add(1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd3);
        add(1'b0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        // abort: requester 1, len 10, dropped at cnt 4
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd1);
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd2);
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd3);
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd4);
        add(1'b0, 4'b0000, 16'h00A0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        // ptr now 2: scan 2,3,0 picks 0 (len 0)
        add(1'b0, 4'b0011, 16'h00A0, 4'b0001, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b0011, 16'h00A0, 4'b0000, 4'b0001, 1'b1, 4'd0);
        add(1'b0, 4'b0010, 16'h00A0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        // requester 1 granted len 10; later length changes are ignored
        add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd1);
        add(1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd2);
        add(1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd3);
        add(1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd4);
        add(1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd5);
        // reset mid-run, then requester 3 with len 2
        add(1'b1, 4'b0010, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        add(1'b0, 4'b1000, 16'h2000, 4'b1000, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b1000, 16'h2000, 4'b1000, 4'b0000, 1'b1, 4'd1);
        add(1'b0, 4'b1000, 16'h2000, 4'b1000, 4'b0000, 1'b1, 4'd2);
        add(1'b0, 4'b1000, 16'h2000, 4'b0000, 4'b1000, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i].rst, vecs[i].req, vecs[i].len, vecs[i].exp);
        end

        // All requesting, len 0: order 0,1,2,3,0 with a 3-cycle cadence.
        for (int g = 0; g < 5; g++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (g % 4);
            step("all_gnt",  g, 1'b0, 4'b1111, 16'h0000, mk(oh, 4'b0000, 1'b1, 4'd0));
            step("all_done", g, 1'b0, 4'b1111, 16'h0000, mk(4'b0000, oh, 1'b1, 4'd0));
            step("all_gap",  g, 1'b0, 4'b1111, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));
        end
        step("all_idle", 0, 1'b0, 4'b0000, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));

        // Serve 2, then 0101 must go to 0 (ptr 3 scans 3,0) before 2.
        step("rr", 0, 1'b0, 4'b0100, 16'h0000, mk(4'b0100, 4'b0000, 1'b1, 4'd0));
        step("rr", 1, 1'b0, 4'b0100, 16'h0000, mk(4'b0000, 4'b0100, 1'b1, 4'd0));
        step("rr", 2, 1'b0, 4'b0101, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));
        step("rr", 3, 1'b0, 4'b0101, 16'h0000, mk(4'b0001, 4'b0000, 1'b1, 4'd0));
        step("rr", 4, 1'b0, 4'b0101, 16'h0000, mk(4'b0000, 4'b0001, 1'b1, 4'd0));
        step("rr", 5, 1'b0, 4'b0100, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));
        step("rr", 6, 1'b0, 4'b0100, 16'h0000, mk(4'b0100, 4'b0000, 1'b1, 4'd0));
        step("rr", 7, 1'b0, 4'b0100, 16'h0000, mk(4'b0000, 4'b0100, 1'b1, 4'd0));
        step("rr", 8, 1'b0, 4'b0000, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));

        // Maximum length 15: 16 grant cycles, no wrap; other requesters
        // toggling and length changes during the run must not matter.
        for (int k = 0; k < 16; k++) begin
            logic [3:0] rq;
            rq = ((k % 2) == 1 && k < 10) ? 4'b0011 : 4'b0001;
            step("max", k, 1'b0, rq, (k == 0) ? 16'h000F : 16'h0002,
                 mk(4'b0001, 4'b0000, 1'b1, 4'(k)));
        end
        step("max_done", 0, 1'b0, 4'b0001, 16'h0000, mk(4'b0000, 4'b0001, 1'b1, 4'd0));
        step("max_end",  0, 1'b0, 4'b0000, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));
        step("max_end",  1, 1'b0, 4'b0000, 16'h0000, mk(4'b0000, 4'b0000, 1'b0, 4'd0));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
